// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves S = BLOCK*GROUPS_PER_STAGE bits; the inter-stage carry is registered.
module pipe_cla_adder #(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int S      = BLOCK * GROUPS_PER_STAGE;
  localparam int STAGES = WIDTH / S;

  if (BLOCK < 1 || GROUPS_PER_STAGE < 1 || (WIDTH % S) != 0) begin : g_bad_params
    $error("pipe_cla_adder: WIDTH must be a multiple of BLOCK*GROUPS_PER_STAGE");
  end

  // Returns {carry into slice MSB, slice carry-out, slice sum}. Each group carry is a
  // flat sum of products of g/p terms and the group carry-in; groups chain in order.
  function automatic logic [S+1:0] cla_slice(input logic [S-1:0] x,
                                             input logic [S-1:0] y,
                                             input logic         ci);
    logic [S-1:0] p;
    logic [S-1:0] g;
    logic [S:0]   c;
    logic         acc;
    logic         term;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < GROUPS_PER_STAGE; grp++) begin
      for (int j = 0; j < BLOCK; j++) begin
        acc = c[grp*BLOCK];
        for (int m = 0; m <= j; m++) acc = acc & p[grp*BLOCK+m];
        for (int m = 0; m <= j; m++) begin
          term = g[grp*BLOCK+m];
          for (int n = m + 1; n <= j; n++) term = term & p[grp*BLOCK+n];
          acc = acc | term;
        end
        c[grp*BLOCK+j+1] = acc;
      end
    end
    return {c[S-1], c[S], p ^ c[S-1:0]};
  endfunction

  // Bank k holds the beat that stage k works on: operands still pending in the upper
  // slices, finished sum slices below, and the carry into slice k.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  s_q   [STAGES];
  logic              c_q   [STAGES];
  logic [STAGES-1:0] v_q;
  logic [S+1:0]      res   [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];

  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              advance;

  // One global enable: the whole pipe moves unless a result is waiting on downstream.
  assign advance   = !(out_valid_q && !out_ready);
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // NOTE: every variable is fully assigned before any partial update, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res[k]               = cla_slice(a_q[k][k*S +: S], b_q[k][k*S +: S], c_q[k]);
      s_nxt[k]             = s_q[k];
      s_nxt[k][k*S +: S]   = res[k][S-1:0];
    end
  end

  // Control and result registers: valid bits and the visible outputs are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) v_q[k] <= v_q[k-1];
      out_valid_q <= v_q[STAGES-1];
      if (v_q[STAGES-1]) begin
        sum_q  <= s_nxt[STAGES-1];
        cout_q <= res[STAGES-1][S];
        ovf_q  <= res[STAGES-1][S+1] ^ res[STAGES-1][S];
      end
    end
  end

  // NOTE: datapath banks carry no reset; their contents are meaningless unless the
  // matching valid bit is set, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (advance) begin
      a_q[0] <= a;
      b_q[0] <= sub ? ~b : b;
      c_q[0] <= sub | cin;
      s_q[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        c_q[k] <= res[k-1][S];
        s_q[k] <= s_nxt[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: directed vectors, stall/reset sequences and
// randomized traffic on three parametrisations against an arithmetic reference model.
module tb_pipe_cla_adder;

  localparam int STAGES = 4;
  localparam int NBEATS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_lat = 1'b1;

  always @(posedge clk) cyc++;

  // Default 32-bit instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  // 16-bit, one group per stage
  logic        v16, r16, cin16, sub16, ov16, ordy16, co16, of16;
  logic [15:0] a16, b16, s16;
  // 64-bit, four groups per stage
  logic        v64, r64, cin64, sub64, ov64, ordy64, co64, of64;
  logic [63:0] a64, b64, s64;

  pipe_cla_adder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  pipe_cla_adder #(.WIDTH(16), .BLOCK(4), .GROUPS_PER_STAGE(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .sum(s16),
    .cout(co16), .ovf(of16));

  pipe_cla_adder #(.WIDTH(64), .BLOCK(4), .GROUPS_PER_STAGE(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .a(a64), .b(b64),
    .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(ordy64), .sum(s64),
    .cout(co64), .ovf(of64));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition of the prepared operands; overflow from operand signs.
  function automatic logic [65:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                        input logic ci, input logic sb);
    logic [63:0] mask, am, be, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    be   = (sb ? ~bv : bv) & mask;
    full = {1'b0, am} + {1'b0, be} + {64'd0, (sb | ci)};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  typedef struct { logic [65:0] res; int cyc; } exp_t;
  typedef struct { logic [31:0] sum; logic cout; logic ovf; int cyc; } got_t;
  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;

  exp_t        exp_q[$];
  got_t        got_q[$];
  logic [65:0] exp16_q[$];
  logic [65:0] exp64_q[$];

  // Scoreboards: handshakes are sampled just after the falling edge, i.e. they
  // describe what the next rising edge will do.
  always begin : mon32
    exp_t e;
    @(negedge clk); #1;
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        got_q.push_back('{sum: sum, cout: cout, ovf: ovf, cyc: cyc});
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out32_unexpected: got sum %h with no beat outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          check("res32", {ovf, cout, 32'h0, sum}, e.res);
          if (chk_lat) check("lat32", cyc - e.cyc - 1, STAGES);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{res: model(32, {32'h0, a}, {32'h0, b}, cin, sub), cyc: cyc});
    end
  end

  always begin : mon16
    @(negedge clk); #1;
    if (rst) exp16_q.delete();
    else begin
      if (ov16 && ordy16) begin
        if (exp16_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out16_unexpected: got sum %h with no beat outstanding", s16);
        end else check("res16", {of16, co16, 48'h0, s16}, exp16_q.pop_front());
      end
      if (v16 && r16) exp16_q.push_back(model(16, {48'h0, a16}, {48'h0, b16}, cin16, sub16));
    end
  end

  always begin : mon64
    @(negedge clk); #1;
    if (rst) exp64_q.delete();
    else begin
      if (ov64 && ordy64) begin
        if (exp64_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out64_unexpected: got sum %h with no beat outstanding", s64);
        end else check("res64", {of64, co64, s64}, exp64_q.pop_front());
      end
      if (v64 && r64) exp64_q.push_back(model(64, a64, b64, cin64, sub64));
    end
  end

  // Present a beat from the next falling edge and hold it until the DUT takes it.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("send_accepted", in_ready, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); #1; n++; end
    check("drain_done", n < 100, 1'b1);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[10];
    logic [31:0] held;
    int n;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 32'h0000_000C, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[9] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
    v64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; ordy64 = 1'b1;

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_flags_sum", {ovf, cout, sum}, 34'h0);
    check("rst_in_ready", in_ready, 1'b1);

    // Directed vectors, one beat at a time
    foreach (vecs[i]) begin
      got_q.delete();
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      idle();
      drain();
      check($sformatf("vec%0d_count", i), got_q.size(), 1);
      if (got_q.size() > 0)
        check($sformatf("vec%0d_result", i), {got_q[0].ovf, got_q[0].cout, got_q[0].sum},
              {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
    end

    // Back-to-back stream of 8 beats
    got_q.delete();
    for (int i = 0; i < 8; i++) send(32'(i), 32'(3 * i), i[0], 1'b0);
    idle();
    drain();
    check("stream_count", got_q.size(), 8);
    for (int j = 0; j < got_q.size(); j++) begin
      check($sformatf("stream%0d_sum", j), got_q[j].sum, 32'(4 * j + (j & 1)));
      if (j > 0) check($sformatf("stream%0d_gap", j), got_q[j].cyc - got_q[j-1].cyc, 1);
    end

    // Downstream stall for 3 cycles with the pipe full and upstream still pushing
    chk_lat = 1'b0;
    got_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'(100 + i), 32'(i), 1'b0, 1'b0);
        idle();
      end
      begin
        n = 0;
        #1;
        while (!out_valid && n < 50) begin @(negedge clk); #1; n++; end
        check("stall_output_seen", out_valid, 1'b1);
        held = sum;
        check("stall_first_sum", held, 32'd100);
        for (int k = 0; k < 3; k++) begin
          check("stall_in_ready", in_ready, 1'b0);
          check("stall_hold", {out_valid, sum}, {1'b1, held});
          if (k < 2) begin @(negedge clk); #1; end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;
    check("stall_count", got_q.size(), 6);
    for (int j = 0; j < got_q.size(); j++)
      check($sformatf("stall%0d_order", j), got_q[j].sum, 32'(100 + 2 * j));

    // Reset with three beats in flight
    got_q.delete();
    for (int i = 0; i < 3; i++) send(32'(200 + i), 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_sum", {ovf, cout, sum}, 34'h0);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_valid", out_valid, 1'b0);
      @(negedge clk); #1;
    end
    send(32'd5, 32'd6, 1'b0, 1'b0);
    idle();
    drain();
    check("midrst_count", got_q.size(), 1);
    if (got_q.size() > 0) check("midrst_sum11", got_q[0].sum, 32'd11);

    // Random traffic on all three instances with random backpressure
    chk_lat = 1'b0;
    begin
      int n32 = 0, nn16 = 0, nn64 = 0, cycles = 0;
      while ((n32 < NBEATS || nn16 < NBEATS || nn64 < NBEATS) && cycles < 40000) begin
        @(negedge clk);
        in_valid  = (n32 < NBEATS) && ($urandom_range(3) != 0);
        a         = $urandom;
        b         = ($urandom_range(3) == 0) ? ~a : 32'($urandom);
        cin       = 1'($urandom_range(1));
        sub       = 1'($urandom_range(1));
        out_ready = ($urandom_range(3) != 0);
        v16       = (nn16 < NBEATS) && ($urandom_range(3) != 0);
        a16       = 16'($urandom);
        b16       = ($urandom_range(3) == 0) ? ~a16 : 16'($urandom);
        cin16     = 1'($urandom_range(1));
        sub16     = 1'($urandom_range(1));
        ordy16    = ($urandom_range(3) != 0);
        v64       = (nn64 < NBEATS) && ($urandom_range(3) != 0);
        a64       = {$urandom, $urandom};
        b64       = ($urandom_range(3) == 0) ? ~a64 : {$urandom, $urandom};
        cin64     = 1'($urandom_range(1));
        sub64     = 1'($urandom_range(1));
        ordy64    = ($urandom_range(3) != 0);
        #1;
        if (in_valid && in_ready) n32++;
        if (v16 && r16) nn16++;
        if (v64 && r64) nn64++;
        cycles++;
      end
      check("random_budget", cycles < 40000, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0; v16 = 1'b0; v64 = 1'b0;
    out_ready = 1'b1; ordy16 = 1'b1; ordy64 = 1'b1;
    n = 0;
    #1;
    while ((exp_q.size() + exp16_q.size() + exp64_q.size()) != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("final_drain", n < 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
Name: pipe_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the 16-bit combinational CLA in the adders library. Operands are split into BLOCK-bit lookahead groups. GROUPS_PER_STAGE groups are resolved per pipeline stage, and the ripple carry between stages is registered. A valid/ready handshake on both sides supports backpressure, so the block drops into streaming datapaths (ALU, accumulator, DSP chains).

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of BLOCK*GROUPS_PER_STAGE.
BLOCK, 4, bits per carry-lookahead group (full 4-term lookahead inside a group).
GROUPS_PER_STAGE, 2, lookahead groups resolved per pipeline stage.
(derived) STAGES = WIDTH/(BLOCK*GROUPS_PER_STAGE); default 4.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored)
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB (in sub mode, 1 = no borrow)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: one cycle with rst=1 clears every stage valid bit, so out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight beats; no partial result ever appears.
- Accept: a beat is accepted when in_valid && in_ready at the clock edge.
- Stall: in_ready = !(out_valid && !out_ready). The pipeline is a single global stall. When stalled, every stage register (data, carry, valid) holds, and sum/cout/ovf stay stable while out_valid=1.
- Latency: exactly STAGES cycles from accept to out_valid, absent stalls (default 4). Throughput is 1 beat/cycle when out_ready=1.
- Operand prep at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) handles bits [k*S +: S], where S = BLOCK*GROUPS_PER_STAGE:
  - Per bit: p = a^b_eff, g = a&b_eff.
  - Per group: carries inside a group use full lookahead equations (c[j+1] = g[j] | p[j]&c[j] expanded, no ripple). Correct term p[i+2]&p[i+1]&p[i]&c for carry 3.
  - Group carry-outs within a stage chain combinationally.
  - The stage carry-out is registered into stage k+1.
- Skew: operand slices for stage k are delayed k cycles (triangular input skew). Finished sum slices are delayed (STAGES-1-k) cycles (output deskew), so all WIDTH bits of a beat emerge together.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = c[WIDTH-1] ^ c[WIDTH], registered alongside sum.
- Width: sum is WIDTH bits with modulo-2^WIDTH wrap. No saturation.
- Simultaneous events:
  - Accept and emit in the same cycle is legal.
  - Stall with in_valid=1 does not accept (in_ready=0); the upstream holds its beat.
  - Bubbles (in_valid=0) propagate as invalid stages and never cause out_valid.
- Invalid parameter combination (WIDTH % S != 0) must fail elaboration.

Test Plan:
- Reset then a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0 -> after 4 cycles: sum=0x0000_0000, cout=1, ovf=0 (full carry chain across all stages).
- a=0x7FFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> sum=0x8000_0000, cout=0, ovf=1. Then sub=1 with a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-to-back stream of 8 beats (a=i, b=3*i, cin=i&1) with out_ready=1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept, each sum=4*i+(i&1).
- Drive out_ready=0 for 3 cycles while 4 beats are in flight -> in_ready=0 during the stall, the held output is stable, no beat is lost or duplicated, and order is preserved after release.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid stays 0 for the following 4 cycles, and the next accepted beat (a=5, b=6) gives sum=11 at latency 4.
- Reparametrise WIDTH=16, BLOCK=4, GROUPS_PER_STAGE=1 (latency 4) and WIDTH=64, GROUPS_PER_STAGE=4. Run 10k random beats with random out_ready against a behavioural {cout,sum}=a+b_eff+c0 model -> zero mismatches.
